// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver (start, DATA_BITS LSB-first, odd parity, stop) feeding a show-ahead FIFO.
// Parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN; otherwise the parity bit is ignored.
module ps2_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wait_for_incoming_data,
  input  logic                          start_receiving_data,
  input  logic                          ps2_clk_posedge,
  input  logic                          ps2_clk_negedge,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_error,
  output logic                          frame_error,
  output logic                          overflow,
  output logic                          timeout_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FOR_DATA,
    DATA_IN,
    PARITY_IN,
    STOP_IN
  } state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [BW-1:0]          bit_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic                   parity_bit;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  logic                   unused_negedge;
  logic                   par_fail;
  logic                   stop_seen;
  logic                   frame_good;
  logic                   full;
  logic                   pop;
  logic                   push;

  assign unused_negedge = ps2_clk_negedge;

`ifdef PS2_RX_PARITY_CHECK_EN
  // Odd parity: data plus parity bit must carry an odd number of ones.
  assign par_fail = ~(^{shift_reg, parity_bit});
`else
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign par_fail      = 1'b0;
`endif

  assign stop_seen  = (state == STOP_IN) && ps2_clk_posedge;
  assign frame_good = stop_seen && ps2_data && !par_fail;
  assign full       = (count == FULL_CNT);
  assign pop        = rd_en && (count != '0);
  // A full FIFO still accepts a frame when a pop frees the head in the same cycle.
  assign push       = frame_good && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overflow      <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overflow      <= 1'b0;
      timeout_error <= 1'b0;
      if (state != DATA_IN) bit_cnt <= '0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (wait_for_incoming_data) begin
            state <= WAIT_FOR_DATA;
          end else if (start_receiving_data) begin
            state <= DATA_IN;
          end
        end
        WAIT_FOR_DATA: begin
          tmo_cnt <= '0;
          if (ps2_clk_posedge && !ps2_data) begin
            state <= DATA_IN;
          end else if (!wait_for_incoming_data) begin
            state <= IDLE;
          end
        end
        DATA_IN, PARITY_IN, STOP_IN: begin
          if (ps2_clk_posedge) begin
            tmo_cnt <= '0;
            case (state)
              DATA_IN: begin
                shift_reg <= {ps2_data, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + BW'(1);
                if (bit_cnt == BIT_LAST) state <= PARITY_IN;
              end
              PARITY_IN: begin
                parity_bit <= ps2_data;
                state      <= STOP_IN;
              end
              default: begin
                state <= IDLE;
                if (!ps2_data) begin
                  frame_error <= 1'b1;
                end else if (par_fail) begin
                  parity_error <= 1'b1;
                end else if (full && !pop) begin
                  overflow <= 1'b1;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            timeout_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, LSB first, range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000, meaning clk cycles allowed between ps2_clk_posedge pulses mid-frame.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wait_for_incoming_data  input  1  arm receiver to hunt for a start bit.
REQ-007 SHALL have port start_receiving_data  input  1  start bit already consumed; enter data phase directly.
REQ-008 SHALL have port ps2_clk_posedge  input  1  single-cycle pulse, PS/2 clock rising edge.
REQ-009 SHALL have port ps2_clk_negedge  input  1  single-cycle pulse, PS/2 clock falling edge; unused, reserved.
REQ-010 SHALL have port ps2_data  input  1  synchronised PS/2 data line.
REQ-011 SHALL have port rd_en  input  1  pop head entry when rd_valid=1.
REQ-012 SHALL have port rd_data  output  DATA_BITS  FIFO head, show-ahead.
REQ-013 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-014 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 SHALL have ports parity_error, frame_error, overflow, timeout_error  output  1 each  single-cycle error pulses.

Function
REQ-016 SHALL implement states IDLE, WAIT_FOR_DATA, DATA_IN, PARITY_IN, STOP_IN; sample ps2_data only in cycles with ps2_clk_posedge=1.
REQ-017 IDLE: wait_for_incoming_data=1 -> WAIT_FOR_DATA; else start_receiving_data=1 -> DATA_IN; wait has priority.
REQ-018 WAIT_FOR_DATA: posedge with ps2_data=0 -> DATA_IN; else wait_for_incoming_data=0 -> IDLE; else hold.
REQ-019 DATA_IN: each posedge shifts ps2_data into MSB of shift register and increments bit counter; posedge on bit DATA_BITS-1 -> PARITY_IN; counter clears outside DATA_IN.
REQ-020 PARITY_IN: posedge captures parity bit -> STOP_IN.
REQ-021 STOP_IN: posedge -> IDLE; frame is valid when stop bit=1 and (data bits + parity) hold an odd number of ones.
REQ-022 Valid frame SHALL be written to FIFO in the stop-bit posedge cycle; rd_valid/rd_data reflect it on the next clk.
REQ-023 Stop bit=0 SHALL drop frame and pulse frame_error one cycle; frame_error has priority over parity_error (only one pulses).
REQ-024 Timeout counter SHALL clear on every posedge and on entering DATA_IN; reaching TIMEOUT_CYCLES-1 in DATA_IN/PARITY_IN/STOP_IN -> IDLE, drop partial frame, pulse timeout_error.
REQ-025 rd_en with rd_valid=0 SHALL be ignored; count never underflows.
REQ-026 Valid frame while full and rd_en=0 SHALL be dropped, FIFO unchanged, overflow pulsed.
REQ-027 Valid frame while full with rd_en=1 SHALL pop and push same cycle; count unchanged, no overflow.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count = writes - reads, 0..FIFO_DEPTH.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, counters 0, pointers 0, fifo_count 0, rd_valid 0, rd_data 0, all error pulses 0.
REQ-030 Reset mid-frame SHALL discard partial frame and all FIFO contents; first posedge after release is ignored unless wait/start are asserted.

Configuration
REQ-031 Macro PS2_RX_PARITY_CHECK_EN defined: parity checked per REQ-021, failing frame dropped, parity_error pulsed one cycle.
REQ-032 Macro PS2_RX_PARITY_CHECK_EN undefined: parity bit consumed but ignored, parity_error tied 0, frame accepted on stop bit=1 alone.

Verification
REQ-033 Defaults, wait=1, frame start0, data 0x1C LSB-first, parity 0, stop1 -> next clk rd_valid=1, rd_data=0x1C, fifo_count=1.
REQ-034 Same frame with parity 1 (macro defined) -> parity_error one-cycle pulse, rd_valid stays 0; macro undefined -> 0x1C stored.
REQ-035 Five valid frames 0x01..0x05, rd_en=0, depth 4 -> count=4, overflow on fifth; read out 0x01..0x04 in order.
REQ-036 Full FIFO, sixth frame stop cycle coincident with rd_en=1 -> count stays 4, no overflow, head advances to 0x02.
REQ-037 Stall after 3 data bits for TIMEOUT_CYCLES clks -> timeout_error pulse, state IDLE, count unchanged; stop bit=0 frame -> frame_error only.
